muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Iterative multiply/divide controller. Owns the HI/LO registers and sequences one radix-2
//  multiply/divide over WIDTH cycles. Replaces the combinational mult/div + Lo/Hi register pair
//  in the CPU core. Raises busy/stall so the pipeline holds mfhi/mflo and new mult/div until done.
// PARAMETERS
//  WIDTH  32  operand width; product/quotient pair is 2*WIDTH; iteration count = WIDTH
// PORTS
//  clk          in   1      clock; all state updates on rising edge
//  rst          in   1      synchronous, active-high reset
//  start        in   1      request op; accepted only when busy==0
//  is_mult      in   1      1=mult(u), 0=div(u); sampled with start
//  is_unsigned  in   1      1=unsigned op; sampled with start
//  a            in   WIDTH  rs operand (dividend / multiplicand); sampled with start
//  b            in   WIDTH  rt operand (divisor / multiplier); sampled with start
//  hilo_rd      in   1      mfhi/mflo request this cycle
//  rd_is_hi     in   1      1=read HI, 0=read LO
//  rdata        out  WIDTH  rd_is_hi ? HI : LO (combinational from registers)
//  busy         out  1      op in flight (state != IDLE)
//  stall        out  1      (hilo_rd | start) & busy
//  done         out  1      1-cycle pulse: HI/LO updated at this cycle's start edge
//  div0         out  1      divide-by-zero pulse with done (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, HI=LO=0, busy=0, done=0, div0=0, iteration count=0. Reset mid-op aborts;
//   HI/LO return to 0; no done pulse is generated.
//  FSM: IDLE -> PREP -> CALC (WIDTH iterations) -> FIX -> IDLE.
//   IDLE: start=1 latches operands/op -> PREP. start while busy is ignored; the CPU stalls it.
//   PREP: for signed ops, take |a| and |b|; record sign(result) and sign(dividend).
//   CALC: one shift-add (mult) or one restoring subtract-shift (div) per cycle, count 0..WIDTH-1.
//   FIX: negate the product if signs differ. Negate the quotient if signs differ; the remainder
//    takes the dividend's sign. Write HI/LO. Next state IDLE; done=1 in that IDLE cycle.
//  Latency: accept edge E0. HI/LO are written at edge E0+WIDTH+2 (=E34). done is high in the
//   following cycle. busy is high from after E0 until E34.
//  Results: mult -> {HI,LO} = 2*WIDTH-bit product. div -> LO=quotient, HI=remainder.
//  Signed corner: 0x80000000 / -1 -> LO=0x80000000, HI=0. No trap.
//  Divide by zero (b==0): LO=all ones, HI=a (raw operand), for signed and unsigned alike.
//  Reads: rdata always reflects the current HI/LO. A hilo_rd in the same IDLE cycle as an accepted
//   start returns the pre-op value and does not stall. A read in the done cycle sees new values.
//  overflow is never flagged by this block.
// CONFIGURATION
//  MUL_DIV_DIV0_FLAG_EN defined:
//   - div with b==0 skips CALC: PREP -> FIX, total latency 3 edges.
//   - div0 pulses together with done.
//  Not defined:
//   - div0 is tied to 0.
//   - b==0 runs the full WIDTH iterations, with the same HI/LO result.
// TESTING
//  multu a=0xFFFFFFFF b=0xFFFFFFFF -> after 35 edges HI=0xFFFFFFFE LO=0x00000001, one done pulse
//  mult a=-7 b=3 -> HI=0xFFFFFFFF LO=0xFFFFFFEB; div a=-7 b=2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF
//  div a=0x80000000 b=0xFFFFFFFF -> LO=0x80000000 HI=0; divu a=100 b=0 -> LO=0xFFFFFFFF HI=100
//   (div0=1 and latency 3 with MUL_DIV_DIV0_FLAG_EN)
//  hilo_rd=1 at cycle 10 of a mult -> stall=1 until done cycle; start during busy is ignored (HI/LO
//   are from the first op only)
//  rst=1 at cycle 20 of a divu -> next cycle busy=0, HI=LO=0, no done; new start then completes
//   normally

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 multiply/divide sequencer that owns the HI/LO pair and stalls the pipeline while busy.
// Optional MUL_DIV_DIV0_FLAG_EN: divide-by-zero skips the iterations and raises div0 together with done.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_mult,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hilo_rd,
  input  logic             rd_is_hi,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div0
);
  // state | meaning
  // IDLE  | waiting for start, HI/LO stable
  // PREP  | take magnitudes, record result/remainder signs
  // CALC  | one shift-add or restoring subtract-shift per cycle
  // FIX   | apply signs, write HI/LO, pulse done on exit
  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] op_a, op_b, m_reg, acc_hi, acc_lo;
  logic             op_mult, op_uns, neg_res, neg_rem, b_zero;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0]   a_abs, b_abs, quo_fix, rem_fix;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic               skip_calc;

  always_comb begin
    a_abs     = (!op_uns && op_a[WIDTH-1]) ? -op_a : op_a;
    b_abs     = (!op_uns && op_b[WIDTH-1]) ? -op_b : op_b;
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m_reg} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, m_reg};
    prod_raw  = {acc_hi, acc_lo};
    prod_fix  = neg_res ? -prod_raw : prod_raw;
    quo_fix   = neg_res ? -acc_lo : acc_lo;
    rem_fix   = neg_rem ? -acc_hi : acc_hi;
  end

`ifdef MUL_DIV_DIV0_FLAG_EN
  assign skip_calc = !op_mult && b_zero;

  always_ff @(posedge clk) begin
    if (rst) div0 <= 1'b0;
    else     div0 <= (state == FIX) && !op_mult && b_zero;
  end
`else
  assign skip_calc = 1'b0;
  assign div0      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      hi      <= '0;
      lo      <= '0;
      op_a    <= '0;
      op_b    <= '0;
      m_reg   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      op_mult <= 1'b0;
      op_uns  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      cnt     <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_a    <= a;
          op_b    <= b;
          op_mult <= is_mult;
          op_uns  <= is_unsigned;
          b_zero  <= (b == '0);
          state   <= PREP;
        end
        PREP: begin
          neg_res <= !op_uns && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          neg_rem <= !op_uns && op_a[WIDTH-1];
          acc_hi  <= '0;
          acc_lo  <= op_mult ? b_abs : a_abs;
          m_reg   <= op_mult ? a_abs : b_abs;
          cnt     <= '0;
          state   <= skip_calc ? FIX : CALC;
        end
        CALC: begin
          if (op_mult) begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end else if (!div_diff[WIDTH]) begin
            acc_hi <= div_diff[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi <= div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          // divide-by-zero result is defined on the raw operand, independent of signedness
          if (op_mult) begin
            {hi, lo} <= prod_fix;
          end else if (b_zero) begin
            hi <= op_a;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rdata = rd_is_hi ? hi : lo;
  assign busy  = (state != IDLE);
  assign stall = (hilo_rd | start) & busy;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer; expectations are hand-computed constants.
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, is_mult, is_unsigned, hilo_rd, rd_is_hi;
  logic [31:0] a, b, rdata;
  logic        busy, stall, done, div0;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef MUL_DIV_DIV0_FLAG_EN
  localparam int DIV0_LAT = 2;
  localparam logic DIV0_EXP = 1'b1;
`else
  localparam int DIV0_LAT = 34;
  localparam logic DIV0_EXP = 1'b0;
`endif

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_mult(is_mult), .is_unsigned(is_unsigned),
    .a(a), .b(b), .hilo_rd(hilo_rd), .rd_is_hi(rd_is_hi), .rdata(rdata),
    .busy(busy), .stall(stall), .done(done), .div0(div0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic start_op(input logic m, input logic u, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1; is_mult = m; is_unsigned = u; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_result(input string tag, input int lat_exp,
                              input logic [31:0] hi_exp, input logic [31:0] lo_exp);
    int n;
    wait_done(n);
    check({tag, "_lat"}, 64'(n), 64'(lat_exp));
    rd_is_hi = 1'b1; #1;
    check({tag, "_hi"}, 64'(rdata), 64'(hi_exp));
    rd_is_hi = 1'b0; #1;
    check({tag, "_lo"}, 64'(rdata), 64'(lo_exp));
    @(posedge clk); #1;
    check({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; is_mult = 1'b0; is_unsigned = 1'b0;
    a = '0; b = '0; hilo_rd = 1'b0; rd_is_hi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_div0", 64'(div0), 64'd0);
    check("rst_lo", 64'(rdata), 64'd0);
    rd_is_hi = 1'b1; #1;
    check("rst_hi", 64'(rdata), 64'd0);
    rd_is_hi = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    start_op(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_busy", 64'(busy), 64'd1);
    check_result("multu", 34, 32'hFFFF_FFFE, 32'h0000_0001);

    start_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd3);
    check_result("mult_neg", 34, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    start_op(1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2);
    check_result("div_neg", 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    start_op(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    check_result("div_ovf", 34, 32'h0000_0000, 32'h8000_0000);

    start_op(1'b0, 1'b1, 32'd100, 32'd0);
    wait_done(n);
    check("divu0_lat", 64'(n), 64'(DIV0_LAT));
    check("divu0_flag", 64'(div0), 64'(DIV0_EXP));
    rd_is_hi = 1'b1; #1;
    check("divu0_hi", 64'(rdata), 64'd100);
    rd_is_hi = 1'b0; #1;
    check("divu0_lo", 64'(rdata), 64'hFFFF_FFFF);
    @(posedge clk); #1;
    check("divu0_flag_clr", 64'(div0), 64'd0);

    // signed divide by zero returns the raw negative dividend in HI
    start_op(1'b0, 1'b0, 32'hFFFF_FFF9, 32'd0);
    check_result("div0_s", DIV0_LAT, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // read in the accepting cycle sees the old LO and does not stall
    hilo_rd = 1'b1; rd_is_hi = 1'b0;
    start = 1'b1; is_mult = 1'b1; is_unsigned = 1'b1; a = 32'd5; b = 32'd6;
    #1;
    check("rd_accept_val", 64'(rdata), 64'hFFFF_FFFF);
    check("rd_accept_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    start = 1'b0; hilo_rd = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      @(posedge clk); #1;
      if (i == 10) begin
        hilo_rd = 1'b1; #1;
        check("stall_rd", 64'(stall), 64'd1);
      end
      if (i == 15) begin
        start = 1'b1; is_mult = 1'b1; a = 32'd9; b = 32'd9; #1;
        check("stall_start", 64'(stall), 64'd1);
      end
      if (i == 16) start = 1'b0;
      if (i == 33) check("stall_last", 64'(stall), 64'd1);
    end
    @(posedge clk); #1;
    check("stall_done", 64'(done), 64'd1);
    check("stall_clear", 64'(stall), 64'd0);
    check("ignored_lo", 64'(rdata), 64'd30);
    hilo_rd = 1'b0;
    @(posedge clk); #1;
    check("ignored_idle", 64'(busy), 64'd0);

    // reset mid-op aborts with no done pulse
    start_op(1'b0, 1'b1, 32'd1000, 32'd7);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_lo", 64'(rdata), 64'd0);
    rd_is_hi = 1'b1; #1;
    check("abort_hi", 64'(rdata), 64'd0);
    rd_is_hi = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    check("abort_no_done", 64'(n), 64'd0);

    start_op(1'b0, 1'b1, 32'd1000, 32'd7);
    check_result("divu_after", 34, 32'd6, 32'd142);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
